// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Sequential ALU for switch/button boards. Operand A and then operand B are
//   loaded from a shared bus on synchronised rising edges of the go button.
//   Single-cycle ops finish in EXEC. MUL and DIV iterate one bit per clock
//   in ITER. The result and flags are held for the LED/7-segment logic.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   0     | LOAD_A : wait for go edge, capture data_in into a_q
//   1     | LOAD_B : wait for go edge, capture data_in into b_q, latch op
//   2     | EXEC   : single-cycle op, write y/flags, pulse done
//   3     | ITER   : MUL/DIV, WIDTH cycles with busy=1, then write y/flags
//   4     | SHOW   : hold result, go edge returns to LOAD_A
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   go, clear           raw button levels (asynchronous)
//   data_in [W]         operand bus
//   op [4]              operation code, latched together with B
//   a_q, b_q [W]        operand registers
//   y [2W]              result register
//   zero/carry/ovf/neg  status flags
//   err                 divide-by-zero flag
//   busy                high while MUL/DIV iterates
//   done                one-cycle pulse when a result is written
//   state [3]           FSM encoding
module alu_seq_core #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [3:0]           op,
  output logic [WIDTH-1:0]     a_q,
  output logic [WIDTH-1:0]     b_q,
  output logic [2*WIDTH-1:0]   y,
  output logic                 zero,
  output logic                 carry,
  output logic                 ovf,
  output logic                 neg,
  output logic                 err,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    EXEC   = 3'd2,
    ITER   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t st;
  assign state = st;

  // Button synchronisers and rising-edge detect
  logic [SYNC_STAGES-1:0] go_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   go_d;
  logic                   clr_d;
  logic                   go_edge;
  logic                   clear_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_sync  <= '0;
      clr_sync <= '0;
      go_d     <= 1'b0;
      clr_d    <= 1'b0;
    end else begin
      go_sync  <= {go_sync[SYNC_STAGES-2:0], go};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], clear};
      go_d     <= go_sync[SYNC_STAGES-1];
      clr_d    <= clr_sync[SYNC_STAGES-1];
    end
  end

  assign go_edge    = go_sync[SYNC_STAGES-1] & ~go_d;
  assign clear_edge = clr_sync[SYNC_STAGES-1] & ~clr_d;

  // Latched op, iteration counter and MUL/DIV working register
  logic [3:0]    op_q;
  logic [CW-1:0] cnt;
  logic [W2-1:0] work;

  // MUL step: work = {partial high, remaining multiplier}; add A then shift right
  logic [W:0]    mul_sum;
  logic [W2-1:0] mul_next;
  assign mul_sum  = {1'b0, work[W2-1:W]} + (work[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, work[W-1:1]};

  // DIV step: work = {remainder, dividend/quotient}; restoring shift-subtract
  logic [W:0]    div_sh;
  logic [W:0]    div_diff;
  logic          div_ge;
  logic [W-1:0]  div_rem;
  logic [W2-1:0] div_next;
  assign div_sh   = {work[W2-1:W], work[W-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_rem  = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
  assign div_next = {div_rem, work[W-2:0], div_ge};

  logic [W2-1:0] iter_next;
  logic          div_zero;
  logic [W2-1:0] iter_final;
  assign iter_next  = (op_q == 4'd14) ? mul_next : div_next;
  assign div_zero   = (op_q == 4'd15) && (b_q == '0);
  assign iter_final = div_zero ? {a_q, {W{1'b1}}} : iter_next;

  // Single-cycle datapath
  logic [W:0]      sum_ext;
  logic [W:0]      dif_ext;
  logic [W:0]      inc_ext;
  logic [W:0]      dec_ext;
  logic [CW-1:0]   amt;
  logic [W:0]      shl_ext;
  logic [W:0]      shr_ext;
  logic [W:0]      sar_ext;
  logic [W2-1:0]   rol_ext;
  logic [W2-1:0]   ror_ext;

  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};
  assign dif_ext = {1'b0, a_q} - {1'b0, b_q};
  assign inc_ext = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, a_q} - {{W{1'b0}}, 1'b1};
  assign amt     = CW'(int'(b_q) % WIDTH);
  // Shifts carry one guard bit so the last bit shifted out lands there
  assign shl_ext = {1'b0, a_q} << amt;
  assign shr_ext = {a_q, 1'b0} >> amt;
  assign sar_ext = $signed({a_q, 1'b0}) >>> amt;
  assign rol_ext = {a_q, a_q} << amt;
  assign ror_ext = {a_q, a_q} >> amt;

  logic [W-1:0] r_res;
  logic         r_c;
  logic         r_v;
  logic         r_wy;

  always_comb begin
    r_res = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_wy  = 1'b1;
    case (op_q)
      4'd0: begin
        r_res = sum_ext[W-1:0];
        r_c   = sum_ext[W];
        r_v   = (a_q[M] == b_q[M]) && (sum_ext[M] != a_q[M]);
      end
      4'd1, 4'd11: begin
        r_res = dif_ext[W-1:0];
        r_c   = dif_ext[W];
        r_v   = (a_q[M] != b_q[M]) && (dif_ext[M] != a_q[M]);
        r_wy  = (op_q == 4'd1);
      end
      4'd2:  r_res = a_q & b_q;
      4'd3:  r_res = a_q | b_q;
      4'd4:  r_res = a_q ^ b_q;
      4'd5:  r_res = ~a_q;
      4'd6: begin
        r_res = shl_ext[W-1:0];
        r_c   = shl_ext[W];
      end
      4'd7: begin
        r_res = shr_ext[W:1];
        r_c   = shr_ext[0];
      end
      4'd8: begin
        r_res = sar_ext[W:1];
        r_c   = sar_ext[0];
      end
      4'd9:  r_res = rol_ext[W2-1:W];
      4'd10: r_res = ror_ext[W-1:0];
      4'd12: begin
        r_res = inc_ext[W-1:0];
        r_c   = inc_ext[W];
        r_v   = ~a_q[M] & inc_ext[M];
      end
      4'd13: begin
        r_res = dec_ext[W-1:0];
        r_c   = dec_ext[W];
        r_v   = a_q[M] & ~dec_ext[M];
      end
      default: r_wy = 1'b0;
    endcase
  end

  // Main FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= LOAD_A;
      a_q   <= '0;
      b_q   <= '0;
      y     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      neg   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_q  <= '0;
      cnt   <= '0;
      work  <= '0;
    end else begin
      done <= 1'b0;
      if (clear_edge) begin
        st    <= LOAD_A;
        a_q   <= '0;
        b_q   <= '0;
        y     <= '0;
        zero  <= 1'b0;
        carry <= 1'b0;
        ovf   <= 1'b0;
        neg   <= 1'b0;
        err   <= 1'b0;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (st)
          LOAD_A: begin
            if (go_edge) begin
              a_q <= data_in;
              st  <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (go_edge) begin
              b_q  <= data_in;
              op_q <= op;
              if (op == 4'd14 || op == 4'd15) begin
                work <= (op == 4'd14) ? {{W{1'b0}}, data_in} : {{W{1'b0}}, a_q};
                cnt  <= CW'(WIDTH - 1);
                busy <= 1'b1;
                st   <= ITER;
              end else begin
                st <= EXEC;
              end
            end
          end
          EXEC: begin
            if (r_wy) y <= {{W{1'b0}}, r_res};
            zero  <= (r_res == '0);
            neg   <= r_res[M];
            carry <= r_c;
            ovf   <= r_v;
            err   <= 1'b0;
            done  <= 1'b1;
            st    <= SHOW;
          end
          ITER: begin
            work <= iter_next;
            if (cnt == '0) begin
              y     <= iter_final;
              zero  <= (iter_final == '0);
              neg   <= (op_q == 4'd14) ? iter_final[W2-1] : 1'b0;
              carry <= 1'b0;
              ovf   <= 1'b0;
              err   <= div_zero;
              busy  <= 1'b0;
              done  <= 1'b1;
              st    <= SHOW;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SHOW: begin
            if (go_edge) st <= LOAD_A;
          end
          default: st <= LOAD_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core
//   Directed bench for alu_seq_core (WIDTH=8 main instance, WIDTH=12 MUL check).
//   Expected results are queued when B is loaded and popped on each done pulse.
module tb_alu_seq_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, go, clear;
  logic [7:0]  data_in;
  logic [3:0]  op;
  logic [7:0]  a_q, b_q;
  logic [15:0] y;
  logic        zero, carry, ovf, neg, err, busy, done;
  logic [2:0]  state;

  logic        go12, clear12;
  logic [11:0] data12;
  logic [3:0]  op12;
  logic [11:0] a12, b12;
  logic [23:0] y12;
  logic        zero12, carry12, ovf12, neg12, err12, busy12, done12;
  logic [2:0]  state12;

  alu_seq_core #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .clear(clear), .data_in(data_in), .op(op),
    .a_q(a_q), .b_q(b_q), .y(y), .zero(zero), .carry(carry), .ovf(ovf), .neg(neg),
    .err(err), .busy(busy), .done(done), .state(state));

  alu_seq_core #(.WIDTH(12), .SYNC_STAGES(3)) dut12 (
    .clk(clk), .reset_n(reset_n), .go(go12), .clear(clear12), .data_in(data12), .op(op12),
    .a_q(a12), .b_q(b12), .y(y12), .zero(zero12), .carry(carry12), .ovf(ovf12), .neg(neg12),
    .err(err12), .busy(busy12), .done(done12), .state(state12));

  typedef struct packed {
    logic [15:0] y;
    logic zero, carry, ovf, neg, err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] prev_y = '0;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model for WIDTH=8, written with plain integer arithmetic
  function automatic exp_t model(input int a, input int b, input int o);
    exp_t e;
    int r, s, n;
    e = '0;
    r = 0;
    n = b % 8;
    case (o)
      0: begin
        s = a + b; r = s & 255; e.carry = (s > 255);
        e.ovf = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      1, 11: begin
        r = (a - b) & 255; e.carry = (a < b);
        e.ovf = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & 255;
      6: begin r = (a << n) & 255; e.carry = (n != 0) && (((a >> (8 - n)) & 1) == 1); end
      7: begin r = a >> n; e.carry = (n != 0) && (((a >> (n - 1)) & 1) == 1); end
      8: begin
        s = (a >= 128) ? a - 256 : a;
        r = (s >>> n) & 255;
        e.carry = (n != 0) && (((a >> (n - 1)) & 1) == 1);
      end
      9:  r = ((a << n) | (a >> (8 - n))) & 255;
      10: r = ((a >> n) | (a << (8 - n))) & 255;
      12: begin s = a + 1; r = s & 255; e.carry = (s > 255); e.ovf = (a == 127); end
      13: begin r = (a - 1) & 255; e.carry = (a == 0); e.ovf = (a == 128); end
      14: r = a * b;
      15: begin
        r = (b == 0) ? ((a << 8) | 255) : (((a % b) << 8) | (a / b));
        e.err = (b == 0);
      end
      default: r = 0;
    endcase
    e.y    = (o == 11) ? prev_y : 16'(r);
    e.zero = (r == 0);
    if (o < 14)       e.neg = ((r >> 7) & 1) == 1;
    else if (o == 14) e.neg = ((r >> 15) & 1) == 1;
    else              e.neg = 1'b0;
    return e;
  endfunction

  // Monitor: timing bookkeeping and scoreboard pop on done
  int   samp = 0, exec_samp = -100, done_samp = -100, done_cnt = 0;
  int   busy_len = 0, last_busy_len = 0, busy_end_samp = -100;
  logic [2:0] prev_st = '0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    samp++;
    if (state == 3'd2 && prev_st == 3'd1) exec_samp = samp;
    if (busy) busy_len++;
    else if (prev_busy) begin
      last_busy_len = busy_len;
      busy_end_samp = samp;
      busy_len = 0;
    end
    if (done) begin
      done_cnt++;
      done_samp = samp;
      if (exp_q.size() == 0) chk("unexpected_done", 32'(exp_q.size()), 32'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk("y", 32'(y), 32'(mon_e.y));
        chk("flags_zcvne", 32'({zero, carry, ovf, neg, err}),
            32'({mon_e.zero, mon_e.carry, mon_e.ovf, mon_e.neg, mon_e.err}));
      end
    end
    prev_st   = state;
    prev_busy = busy;
  end

  int busy12_len = 0, busy12_final = 0, done12_cnt = 0;
  logic [23:0] y12_done = '0;
  always @(negedge clk) begin
    if (busy12) busy12_len++;
    if (done12) begin
      done12_cnt++;
      y12_done     = y12;
      busy12_final = busy12_len;
    end
  end

  task automatic pulse_go(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    go = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_go12(input logic [11:0] d);
    @(negedge clk);
    data12 = d;
    go12 = 1'b1;
    repeat (4) @(negedge clk);
    go12 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(state == 3'd4 && exp_q.size() == 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("op_complete_in_time", 32'(t < 40), 32'd1);
  endtask

  task automatic push_exp(input int a, input int b, input int o);
    exp_t e;
    e = model(a, b, o);
    exp_q.push_back(e);
    prev_y = e.y;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
    push_exp(int'(a), int'(b), int'(o));
    if (state == 3'd4) pulse_go(8'h00);
    pulse_go(a);
    op = o;
    pulse_go(b);
    wait_idle();
  endtask

  int dc;
  int t12;

  initial begin
    reset_n = 1'b0; go = 1'b0; clear = 1'b0; data_in = '0; op = '0;
    go12 = 1'b0; clear12 = 1'b0; data12 = '0; op12 = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_regs", 32'({a_q, b_q, y}), 32'd0);
    chk("reset_flags", 32'({zero, carry, ovf, neg, err, busy, done}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic ADD with done latency
    run_op(8'h2A, 8'h05, 4'd0);
    chk("t1_a_q", 32'(a_q), 32'h2A);
    chk("t1_b_q", 32'(b_q), 32'h05);
    chk("t1_done_latency", 32'(done_samp - exec_samp), 32'd1);
    chk("t1_done_count", 32'(done_cnt), 32'd1);

    // 2: signed overflow and borrow
    run_op(8'h7F, 8'h01, 4'd0);
    run_op(8'h00, 8'h01, 4'd1);

    // 3: MUL with go pulse during busy
    push_exp(255, 255, 14);
    pulse_go(8'h00);
    pulse_go(8'hFF);
    op = 4'd14;
    dc = done_cnt;
    pulse_go(8'hFF);
    pulse_go(8'h55);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("t3_busy_len", 32'(last_busy_len), 32'd8);
    chk("t3_done_after_busy", 32'(done_samp), 32'(busy_end_samp));
    chk("t3_single_done", 32'(done_cnt - dc), 32'd1);
    chk("t3_go_ignored_state", 32'(state), 32'd4);
    chk("t3_go_ignored_a", 32'(a_q), 32'hFF);

    // 4: DIV, divide by zero, err recovery
    run_op(8'd100, 8'd7, 4'd15);
    run_op(8'h10, 8'h00, 4'd15);
    chk("t4_err_held", 32'(err), 32'd1);
    run_op(8'h03, 8'h04, 4'd0);

    // shift/rotate boundaries and the remaining single-cycle ops
    run_op(8'h81, 8'h09, 4'd6);
    run_op(8'h80, 8'h07, 4'd8);
    run_op(8'h81, 8'h0F, 4'd7);
    run_op(8'hA5, 8'h08, 4'd10);
    run_op(8'h7F, 8'h00, 4'd12);
    run_op(8'h80, 8'h00, 4'd13);
    run_op(8'hFF, 8'h00, 4'd12);
    run_op(8'h00, 8'h00, 4'd13);
    run_op(8'h80, 8'h01, 4'd11);
    for (int o = 2; o < 14; o++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(o));

    // 5: held go advances once; clear beats go
    chk("t5_pre_state", 32'(state), 32'd4);
    @(negedge clk);
    go = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5_held_go_state", 32'(state), 32'd0);
    go = 1'b0;
    repeat (3) @(negedge clk);
    run_op(8'h12, 8'h34, 4'd4);
    @(negedge clk);
    go = 1'b1; clear = 1'b1;
    repeat (4) @(negedge clk);
    go = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_clear_state", 32'(state), 32'd0);
    chk("t5_clear_regs", 32'({a_q, b_q, y}), 32'd0);
    chk("t5_clear_flags", 32'({zero, carry, ovf, neg, err, busy}), 32'd0);
    prev_y = '0;

    // 6: reset during ITER aborts without done
    pulse_go(8'h0F);
    op = 4'd14;
    pulse_go(8'h03);
    chk("t6_busy_before_reset", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_reset_state", 32'(state), 32'd0);
    chk("t6_reset_regs", 32'({a_q, b_q, y}), 32'd0);
    chk("t6_reset_flags", 32'({zero, carry, ovf, neg, err, busy, done}), 32'd0);
    exp_q.delete();
    prev_y = '0;
    dc = done_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - dc), 32'd0);
    chk("t6_state_idle", 32'(state), 32'd0);

    // 6b: WIDTH=12 MUL
    busy12_len = 0;
    pulse_go12(12'hFFF);
    op12 = 4'd14;
    pulse_go12(12'h002);
    t12 = 0;
    while (done12_cnt == 0 && t12 < 40) begin
      @(negedge clk);
      t12++;
    end
    chk("w12_done_seen", 32'(done12_cnt), 32'd1);
    chk("w12_y", 32'(y12_done), 32'h001FFE);
    chk("w12_busy_len", 32'(busy12_final), 32'd12);
    chk("w12_flags", 32'({zero12, carry12, ovf12, neg12, err12}), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
